// File: rtl/regread_arbiter.sv
// Two-requester arbiter sharing one register-file read port and the 5->32 sign-extension path.
// Responses come back one at a time, tagged with the requester id.
module regread_arbiter #(
   parameter int RF_LAT   = 1,
   parameter bit FIX_PRIO = 1'b0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [4:0]  req0_addr,
   input  logic        req0_sext,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [4:0]  req1_addr,
   input  logic        req1_sext,
   output logic        rf_ren,
   output logic [4:0]  rf_addr,
   input  logic [31:0] rf_data,
   output logic        rsp_valid,
   output logic        rsp_id,
   output logic [31:0] rsp_data,
   input  logic        rsp_ready,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   typedef struct packed {
      logic [4:0] addr;
      logic       id;
   } req_t;

   localparam logic [1:0] CNT_INIT = 2'(RF_LAT - 1);

   state_t     state, state_nx;
   req_t       req_q;
   logic       rr_ptr;
   logic [1:0] cnt;
   logic       win;
   logic       acc;
   logic [4:0] acc_addr;
   logic       acc_sext;

   // Winner selection; rr_ptr only matters when both requesters are valid.
   always_comb begin
      win = 1'b0;
      if (req0_valid && req1_valid)
         win = FIX_PRIO ? 1'b0 : rr_ptr;
      else if (req1_valid)
         win = 1'b1;
   end

   assign acc        = (state == IDLE) && !reset && (req0_valid || req1_valid);
   assign req0_ready = acc && !win;
   assign req1_ready = acc && win;
   assign acc_addr   = win ? req1_addr : req0_addr;
   assign acc_sext   = win ? req1_sext : req0_sext;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (acc) state_nx = acc_sext ? RESP : ISSUE;
         ISSUE:   state_nx = WAIT;
         WAIT:    if (cnt == 2'd0) state_nx = RESP;
         RESP:    if (rsp_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         req_q    <= '0;
         rr_ptr   <= 1'b0;
         cnt      <= 2'd0;
         rsp_data <= 32'd0;
         rsp_id   <= 1'b0;
      end else begin
         state <= state_nx;
         if (acc) begin
            req_q.addr <= acc_addr;
            req_q.id   <= win;
            if (!FIX_PRIO)
               rr_ptr <= !win;
            // Immediates need no RF access: the response is ready on the accept edge.
            if (acc_sext) begin
               rsp_data <= {{27{acc_addr[4]}}, acc_addr};
               rsp_id   <= win;
            end
         end
         if (state == ISSUE)
            cnt <= CNT_INIT;
         if (state == WAIT) begin
            if (cnt == 2'd0) begin
               rsp_data <= rf_data;
               rsp_id   <= req_q.id;
            end else begin
               cnt <= cnt - 2'd1;
            end
         end
      end
   end

   assign rf_ren    = (state == ISSUE);
   assign rf_addr   = rf_ren ? req_q.addr : 5'd0;
   assign rsp_valid = (state == RESP);
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_regread_arbiter.sv
// Directed bench for regread_arbiter: three instances (RR/RF_LAT=2, RR/RF_LAT=4, fixed/RF_LAT=2)
// share one stimulus; each has its own register-file model.
module tb_regread_arbiter;

   localparam logic [31:0] GARB = 32'hBAD0_BAD0;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       r0v = 1'b0, r0s = 1'b0, r1v = 1'b0, r1s = 1'b0, rspr = 1'b1;
   logic [4:0] r0a = 5'd0, r1a = 5'd0;

   logic        rdy0[3], rdy1[3], ren[3], rv[3], rid[3], bsy[3];
   logic [4:0]  raddr[3];
   logic [31:0] rdat[3], rfd[3];

   logic [3:0]  pv[3];
   logic [4:0]  pa[3][4];

   int npass = 0, ntot = 0;

   always #5 clock = ~clock;

   regread_arbiter #(.RF_LAT(2), .FIX_PRIO(1'b0)) dut_a (
      .clock(clock), .reset(reset),
      .req0_valid(r0v), .req0_ready(rdy0[0]), .req0_addr(r0a), .req0_sext(r0s),
      .req1_valid(r1v), .req1_ready(rdy1[0]), .req1_addr(r1a), .req1_sext(r1s),
      .rf_ren(ren[0]), .rf_addr(raddr[0]), .rf_data(rfd[0]),
      .rsp_valid(rv[0]), .rsp_id(rid[0]), .rsp_data(rdat[0]), .rsp_ready(rspr), .busy(bsy[0]));

   regread_arbiter #(.RF_LAT(4), .FIX_PRIO(1'b0)) dut_b (
      .clock(clock), .reset(reset),
      .req0_valid(r0v), .req0_ready(rdy0[1]), .req0_addr(r0a), .req0_sext(r0s),
      .req1_valid(r1v), .req1_ready(rdy1[1]), .req1_addr(r1a), .req1_sext(r1s),
      .rf_ren(ren[1]), .rf_addr(raddr[1]), .rf_data(rfd[1]),
      .rsp_valid(rv[1]), .rsp_id(rid[1]), .rsp_data(rdat[1]), .rsp_ready(rspr), .busy(bsy[1]));

   regread_arbiter #(.RF_LAT(2), .FIX_PRIO(1'b1)) dut_c (
      .clock(clock), .reset(reset),
      .req0_valid(r0v), .req0_ready(rdy0[2]), .req0_addr(r0a), .req0_sext(r0s),
      .req1_valid(r1v), .req1_ready(rdy1[2]), .req1_addr(r1a), .req1_sext(r1s),
      .rf_ren(ren[2]), .rf_addr(raddr[2]), .rf_data(rfd[2]),
      .rsp_valid(rv[2]), .rsp_id(rid[2]), .rsp_data(rdat[2]), .rsp_ready(rspr), .busy(bsy[2]));

   function automatic logic [31:0] mem(input logic [4:0] a);
      return (a == 5'd7) ? 32'hDEAD_BEEF : (32'h1234_5600 | {27'd0, a});
   endfunction

   // Register-file model: data is valid only RF_LAT cycles after rf_ren, garbage otherwise.
   always @(posedge clock) begin
      for (int d = 0; d < 3; d++) begin
         if (reset) pv[d] <= '0;
         else       pv[d] <= {pv[d][2:0], ren[d]};
         pa[d][0] <= raddr[d];
         for (int k = 1; k < 4; k++) pa[d][k] <= pa[d][k-1];
      end
   end

   assign rfd[0] = pv[0][1] ? mem(pa[0][1]) : GARB;
   assign rfd[1] = pv[1][3] ? mem(pa[1][3]) : GARB;
   assign rfd[2] = pv[2][1] ? mem(pa[2][1]) : GARB;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      ntot++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
   endtask

   // One request on instance d; checks latency, data, id and rf strobe behaviour.
   task automatic txn(input int d, input int who, input logic [4:0] a, input logic s,
                      input logic [31:0] exp, input int lat);
      bit got;
      int n, ren_cnt;
      if (who == 0) begin r0v = 1'b1; r0a = a; r0s = s; end
      else          begin r1v = 1'b1; r1a = a; r1s = s; end
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clock);
         got = (who != 0) ? rdy1[d] : rdy0[d];
         if (!got) @(posedge clock);
      end
      chk("accept", 64'(got), 64'd1);
      @(posedge clock); #1;
      r0v = 1'b0; r1v = 1'b0;
      got = 1'b0; ren_cnt = 0; n = 0;
      while (!got && n < 20) begin
         @(negedge clock);
         n++;
         if (ren[d]) begin
            ren_cnt++;
            chk("rf_addr", 64'(raddr[d]), 64'(a));
         end
         got = rv[d];
         if (!got) @(posedge clock);
      end
      chk("rsp_latency", 64'(n), 64'(lat));
      chk("rsp_data", 64'(rdat[d]), 64'(exp));
      chk("rsp_id", 64'(rid[d]), 64'(who));
      chk("rf_ren_pulses", 64'(ren_cnt), s ? 64'd0 : 64'd1);
      @(posedge clock); #1;
   endtask

   typedef struct {
      int          who;
      logic [4:0]  addr;
      logic        sext;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vt[6];

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [3:0] seqa, seqc;
      int na, nc, both, vcnt;

      vt[0] = '{0, 5'b10000, 1'b1, 32'hFFFF_FFF0, 1};
      vt[1] = '{0, 5'b01111, 1'b1, 32'h0000_000F, 1};
      vt[2] = '{1, 5'd7,     1'b0, 32'hDEAD_BEEF, 4};
      vt[3] = '{0, 5'd0,     1'b0, 32'h1234_5600, 4};
      vt[4] = '{1, 5'b11111, 1'b1, 32'hFFFF_FFFF, 1};
      vt[5] = '{0, 5'd31,    1'b0, 32'h1234_561F, 4};

      repeat (2) @(posedge clock);
      @(negedge clock);
      chk("reset_outputs", 64'({rv[0], rid[0], rdat[0], ren[0], raddr[0], bsy[0], rdy0[0], rdy1[0]}), 64'd0);
      @(posedge clock); #1;
      reset = 1'b0;

      foreach (vt[i]) txn(0, vt[i].who, vt[i].addr, vt[i].sext, vt[i].exp, vt[i].lat);

      // Contention: both requesters hold sext requests continuously.
      do_reset();
      r0v = 1'b1; r0s = 1'b1; r0a = 5'd1;
      r1v = 1'b1; r1s = 1'b1; r1a = 5'd2;
      seqa = '0; seqc = '0; na = 0; nc = 0; both = 0;
      repeat (8) begin
         @(negedge clock);
         if (rdy0[0] && rdy1[0]) both++;
         if (rdy0[2] && rdy1[2]) both++;
         if ((rdy0[0] || rdy1[0]) && na < 4) begin seqa[na] = rdy1[0]; na++; end
         if ((rdy0[2] || rdy1[2]) && nc < 4) begin seqc[nc] = rdy1[2]; nc++; end
         @(posedge clock); #1;
      end
      r0v = 1'b0; r1v = 1'b0;
      chk("rr_order", 64'(seqa), 64'b1010);
      chk("rr_accepts", 64'(na), 64'd4);
      chk("fix_order", 64'(seqc), 64'b0000);
      chk("fix_accepts", 64'(nc), 64'd4);
      chk("ready_exclusive", 64'(both), 64'd0);
      repeat (3) @(posedge clock); #1;

      // Backpressure: response held while rsp_ready is low.
      do_reset();
      rspr = 1'b0;
      r0v = 1'b1; r0s = 1'b1; r0a = 5'b10101;
      @(negedge clock);
      chk("bp_accept", 64'(rdy0[0]), 64'd1);
      @(posedge clock); #1;
      r0a = 5'd1; r0s = 1'b0;
      r1v = 1'b1; r1s = 1'b0; r1a = 5'd3;
      repeat (5) begin
         @(negedge clock);
         chk("bp_hold", 64'({rv[0], rid[0], rdat[0], ren[0], rdy0[0], rdy1[0]}),
             64'({1'b1, 1'b0, 32'hFFFF_FFF5, 1'b0, 1'b0, 1'b0}));
         @(posedge clock); #1;
      end
      rspr = 1'b1;
      @(posedge clock); #1;
      @(negedge clock);
      chk("bp_release", 64'({rv[0], rdy0[0], rdy1[0]}), 64'b001);
      @(posedge clock); #1;
      r0v = 1'b0; r1v = 1'b0;
      repeat (6) @(posedge clock); #1;

      // Reset while a read is in WAIT: request dropped, pointer back to req0.
      do_reset();
      r0v = 1'b1; r0s = 1'b0; r0a = 5'd7;
      @(negedge clock);
      chk("mid_accept", 64'(rdy0[0]), 64'd1);
      @(posedge clock); #1;
      r0v = 1'b0;
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      chk("mid_reset_outputs", 64'({rv[0], rid[0], rdat[0], ren[0], raddr[0], bsy[0], rdy0[0], rdy1[0]}), 64'd0);
      vcnt = 0;
      repeat (6) begin
         @(negedge clock);
         if (rv[0]) vcnt++;
      end
      chk("mid_no_response", 64'(vcnt), 64'd0);
      @(posedge clock); #1;
      r0v = 1'b1; r0s = 1'b1; r0a = 5'd4;
      r1v = 1'b1; r1s = 1'b1; r1a = 5'd5;
      @(negedge clock);
      chk("mid_prio", 64'({rdy0[0], rdy1[0]}), 64'b10);
      @(posedge clock); #1;
      r0v = 1'b0; r1v = 1'b0;
      repeat (3) @(posedge clock); #1;

      // RF_LAT=4 read of r31: only the capture-cycle rf_data may be used.
      do_reset();
      txn(1, 0, 5'd31, 1'b0, 32'h1234_561F, 6);
      repeat (4) @(posedge clock); #1;

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
